// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with branch resolution, return-address stack and halt
module pc_unit #(
  parameter int                 ADDR_W    = 16,
  parameter int                 IMM_W     = 9,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [2:0]        flags,
  input  logic              jr_valid,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              redirect,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int               PTR_W    = $clog2(RAS_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  sp_dec;
  logic [CNT_W-1:0]  count;
  logic              err;
  logic              take;
  logic              z, v, n;
  logic              advance;

  assign {z, v, n}  = flags;
  assign pc_plus2   = pc + ADDR_W'(2);
  assign br_off     = {{(ADDR_W-IMM_W-1){br_imm[IMM_W-1]}}, br_imm, 1'b0};
  assign br_target  = pc_plus2 + br_off;
  // sp points at the next free slot, so the top of stack sits one below it
  assign sp_dec     = sp - PTR_W'(1);
  assign ras_top    = ras_mem[sp_dec];
  assign advance    = (state == RUN) && !stall && !halt;

  always_comb begin
    take = 1'b1;
    case (br_cond)
      3'b000: take = !z;
      3'b001: take = z;
      3'b010: take = !z && !n;
      3'b011: take = n;
      3'b100: take = z || (!z && !n);
      3'b101: take = n || z;
      3'b110: take = v;
      default: take = 1'b1;
    endcase
  end

  always_comb begin
    next_pc = pc_plus2;
    if (ret) next_pc = (count != '0) ? ras_top : pc_plus2;
    else if (call || jr_valid) next_pc = jr_target;
    else if (br_valid && take) next_pc = br_target;
  end

  assign redirect  = advance && (next_pc != pc_plus2);
  assign pc_out    = pc;
  assign halted    = (state == HALTED);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);
  assign ras_err   = err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_VEC;
      sp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (state == RUN && !stall) begin
      if (halt) begin
        state <= HALTED;
      end else begin
        pc <= next_pc;
        if (ret) begin
          if (count != '0) begin
            sp    <= sp_dec;
            count <= count - CNT_W'(1);
          end else begin
            err <= 1'b1;
          end
        end else if (call) begin
          // a full stack wraps onto its oldest slot, which is exactly where sp points
          sp <= sp + PTR_W'(1);
          if (count == FULL_CNT) err <= 1'b1;
          else count <= count + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && !ret && call) ras_mem[sp] <= pc_plus2;
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit against a queue-based reference model
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, halt = 1'b0, br_valid = 1'b0;
  logic        jr_valid = 1'b0, call = 1'b0, ret = 1'b0;
  logic [2:0]  br_cond = 3'd0, flags = 3'd0;
  logic [8:0]  br_imm = 9'd0;
  logic [15:0] jr_target = 16'd0;
  logic [15:0] pc_out, pc_plus2;
  logic        redirect, halted, ras_empty, ras_full, ras_err;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .br_valid(br_valid), .br_cond(br_cond), .br_imm(br_imm), .flags(flags),
    .jr_valid(jr_valid), .call(call), .ret(ret), .jr_target(jr_target),
    .pc_out(pc_out), .pc_plus2(pc_plus2), .redirect(redirect), .halted(halted),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        red;
    logic [15:0] pp;
    logic [15:0] pc;
    logic        hlt, emp, ful, err;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [15:0] m_pc = 16'd0;
  logic [15:0] m_ras[$];
  bit          m_hlt = 1'b0;
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z, v, nn;
    z = f[2]; v = f[1]; nn = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !nn;
      3'd3: return nn;
      3'd4: return z || (!z && !nn);
      3'd5: return nn || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step(input logic st, input logic hl, input logic bv, input logic [2:0] bc,
                      input logic [8:0] bi, input logic [2:0] fl, input logic jv,
                      input logic ca, input logic re, input logic [15:0] jt);
    logic [15:0] pp, nxt;
    logic        red;
    exp_t        e;
    @(negedge clk);
    stall = st; halt = hl; br_valid = bv; br_cond = bc; br_imm = bi; flags = fl;
    jr_valid = jv; call = ca; ret = re; jr_target = jt;
    pp = m_pc + 16'd2; nxt = pp; red = 1'b0;
    if (!m_hlt && !st) begin
      if (hl) m_hlt = 1'b1;
      else begin
        if (re) begin
          if (m_ras.size() > 0) nxt = m_ras.pop_back();
          else m_err = 1'b1;
        end else if (ca) begin
          nxt = jt;
          m_ras.push_back(pp);
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_err = 1'b1;
          end
        end else if (jv) nxt = jt;
        else if (bv && cond_true(bc, fl)) nxt = 16'(int'(pp) + 2 * int'($signed(bi)));
        red  = (nxt != pp);
        m_pc = nxt;
      end
    end
    e.red = red; e.pp = pp; e.pc = m_pc; e.hlt = m_hlt;
    e.emp = (m_ras.size() == 0); e.ful = (m_ras.size() == 4); e.err = m_err;
    sbq.push_back(e);
  endtask

  task automatic idle();                 step(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0); endtask
  task automatic jump(input logic [15:0] t); step(0, 0, 0, 0, 0, 0, 1, 0, 0, t); endtask
  task automatic do_call(input logic [15:0] t); step(0, 0, 0, 0, 0, 0, 0, 1, 0, t); endtask
  task automatic do_ret();               step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0); endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(negedge clk); #3;
    rst = 1'b0;
    m_pc = 16'd0; m_hlt = 1'b0; m_err = 1'b0; m_ras.delete();
    #1;
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ras_empty", ras_empty, 1'b1);
    chk("rst_ras_err", ras_err, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      exp_t        e;
      logic        r;
      logic [15:0] pp;
      @(negedge clk); #2;
      if (sbq.size() != 0) begin
        e  = sbq.pop_front();
        r  = redirect;
        pp = pc_plus2;
        @(posedge clk); #1;
        chk("redirect", r, e.red);
        chk("pc_plus2", pp, e.pp);
        chk("pc_out", pc_out, e.pc);
        chk("halted", halted, e.hlt);
        chk("ras_empty", ras_empty, e.emp);
        chk("ras_full", ras_full, e.ful);
        chk("ras_err", ras_err, e.err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] held;
    #1;
    chk("init_pc", pc_out, 16'h0000);
    chk("init_halted", halted, 1'b0);
    chk("init_ras_empty", ras_empty, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      idle();
      after_edge();
      chk("seq_pc", pc_out, 16'(2 * (i + 1)));
    end

    do_call(16'h0040);
    after_edge();
    chk("pre_rst_pc", pc_out, 16'h0040);
    chk("pre_rst_ras_empty", ras_empty, 1'b0);
    do_reset();

    jump(16'h0010);
    step(0, 0, 1, 3'b001, 9'h1FC, 3'b100, 0, 0, 0, 16'h0);
    #1 chk("br_taken_redirect", redirect, 1'b1);
    after_edge();
    chk("br_taken_pc", pc_out, 16'h000A);
    jump(16'h0010);
    step(0, 0, 1, 3'b001, 9'h1FC, 3'b000, 0, 0, 0, 16'h0);
    #1 chk("br_not_taken_redirect", redirect, 1'b0);
    after_edge();
    chk("br_not_taken_pc", pc_out, 16'h0012);

    jump(16'h0020);
    do_call(16'h0100);
    after_edge();
    chk("call_pc", pc_out, 16'h0100);
    do_ret();
    after_edge();
    chk("ret_pc", pc_out, 16'h0022);
    chk("ret_ras_empty", ras_empty, 1'b1);

    for (int i = 1; i <= 5; i++) do_call(16'(i * 16'h1000));
    after_edge();
    chk("ovf_ras_err", ras_err, 1'b1);
    chk("ovf_ras_full", ras_full, 1'b1);
    for (int i = 4; i >= 1; i--) begin
      do_ret();
      after_edge();
      chk("ovf_ret_pc", pc_out, 16'(i * 16'h1000 + 2));
    end
    do_ret();
    after_edge();
    chk("underflow_pc", pc_out, 16'h1004);
    do_reset();

    for (int seg = 0; seg < 6; seg++) begin
      for (int k = 0; k < 60; k++) begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0, 1'($urandom),
             3'($urandom), 9'($urandom), 3'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 16'($urandom));
      end
      do_reset();
    end

    jump(16'h0010);
    step(1, 0, 1, 3'b111, 9'h010, 3'b000, 0, 0, 0, 16'h0);
    #1 chk("stall_redirect", redirect, 1'b0);
    after_edge();
    chk("stall_pc", pc_out, 16'h0010);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0300);
    after_edge();
    chk("halt_halted", halted, 1'b1);
    held = pc_out;
    chk("halt_pc", held, 16'h0010);
    for (int k = 0; k < 10; k++) begin
      step(0, 1'($urandom), 1'($urandom), 3'($urandom), 9'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      #1 chk("halted_redirect", redirect, 1'b0);
      after_edge();
      chk("halted_pc_frozen", pc_out, 16'h0010);
    end
    do_reset();

    idle();
    after_edge();
    chk("post_halt_pc", pc_out, 16'h0002);
    @(posedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
